// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step on magnitudes.
// Only built when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        // MSB of diff is the borrow: set means the trial subtraction failed
        if (diff[WIDTH]) begin
            rem_o  = shifted[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o  = diff[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/alu_mdu.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Divider datapath present only when MDU_DIV_EN is defined.
module alu_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mult_sum;

`ifdef MDU_DIV_EN
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   step_rem, step_quot;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .quot_i    (acc_q[WIDTH-1:0]),
        .divisor_i (mcand_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );
`endif

    always_comb begin
        sgn      = op_is_signed(op);
        a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
        mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
`ifdef MDU_DIV_EN
        rem_neg_d  = rem_neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_zero_d = 1'b0;
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, b_mag};
                            mcand_d  = a_mag;
                            neg_d    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            cnt_d    = CNT_W'(WIDTH - 1);
                            state_d  = CALC;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            is_div_d = 1'b1;
`ifdef MDU_DIV_EN
                            neg_d     = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_d = sgn && a[WIDTH-1];
                            mcand_d   = b_mag;
                            cnt_d     = CNT_W'(WIDTH - 1);
                            if (b == '0) begin
                                // raw dividend parked in acc so FIX can return it on hi
                                acc_d   = {{WIDTH{1'b0}}, a};
                                dz_d    = 1'b1;
                                state_d = FIX;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, a_mag};
                                dz_d    = 1'b0;
                                state_d = CALC;
                            end
`else
                            dz_d    = 1'b1;
                            state_d = FIX;
`endif
                        end
                        MDU_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
                if (is_div_q) acc_d = {step_rem, step_quot};
`endif
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    div_zero_d = 1'b1;
`ifdef MDU_DIV_EN
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = '1;
`endif
                end else if (is_div_q) begin
`ifdef MDU_DIV_EN
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MDU_DIV_EN
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef MDU_DIV_EN
            rem_neg_q  <= rem_neg_d;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu; follows MDU_DIV_EN the same way as the RTL.
module tb_alu_mdu;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, done, div_zero;
    logic [W-1:0] hi, lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           acc_cyc = 0;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dz  = 1'b0;
        e.lat = W + 1;
        case (o)
            MDU_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {e.hi, e.lo} = p;
            end
            MDU_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                {e.hi, e.lo} = p;
            end
            MDU_DIV, MDU_DIVU: begin
`ifdef MDU_DIV_EN
                if (y == '0) begin
                    e.hi  = x;
                    e.lo  = '1;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if (o == MDU_DIVU) begin
                    e.lo = x / y;
                    e.hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    e.lo = $signed(x) / $signed(y);
                    e.hi = $signed(x) % $signed(y);
                end
`else
                e.dz  = 1'b1;
                e.lat = 1;
`endif
            end
            MDU_MTHI: begin e.hi = x; e.lat = 0; end
            MDU_MTLO: begin e.lo = x; e.lat = 0; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(o, x, y);
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(n < 100), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        push_exp(o, x, y);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
        end
    endtask

    task automatic collect(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        compare_pop(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] prev_hi, prev_lo;
        int busy, stale, n, done_cyc, ndone;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rstn = 1'b1;

        send(MDU_MULT, -32'sd3, 32'd7);              collect("mult_neg");
        send(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);       collect("multu");
        send(MDU_MULT, 32'h8000_0000, 32'h8000_0000); collect("mult_min");
        send(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mult_m1");
        send(MDU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678); collect("multu_big");

        send(MDU_DIV, -32'sd7, 32'd2);               collect("div_neg");
        send(MDU_DIVU, 32'd100, 32'd7);              collect("divu");
        send(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF); collect("div_min");
        send(MDU_DIV, 32'd7, -32'sd2);               collect("div_negb");
        send(MDU_DIV, 32'd8, 32'd2);                 collect("div_8_2");

        send(MDU_DIVU, 32'd5, 32'd0);                collect("divu_zero");
        repeat (3) @(negedge clk);
        check("dz_sticky", 64'(div_zero), 64'd1);
        send(MDU_MULT, 32'd3, 32'd4);
        check("dz_clear", 64'(div_zero), 64'd0);
        collect("mult_after_dz");

        send(MDU_MTLO, 32'hCAFE_0001, 32'd0);        collect("mtlo");

        // request held high through CALC; second op waits for IDLE
        prev_hi = m_hi;
        prev_lo = m_lo;
        @(negedge clk);
        in_valid = 1'b1; op = MDU_MULT; a = 32'd1000; b = -32'sd9;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        push_exp(MDU_MULT, 32'd1000, -32'sd9);
        op = MDU_MULTU; a = 32'h0001_0000; b = 32'h0003_0000;
        busy = 0; stale = 0; n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            if (!in_ready) busy++;
            if (hi !== prev_hi || lo !== prev_lo) stale++;
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check("hs_busy", 64'(busy), 64'(W + 1));
        check("hs_partial", 64'(stale), 64'd0);
        check("hs_ready_at_done", 64'(in_ready), 64'd1);
        compare_pop("hs_first");
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        push_exp(MDU_MULTU, 32'h0001_0000, 32'h0003_0000);
        check("hs_accept_gap", 64'(acc_cyc - done_cyc), 64'd1);
        collect("hs_second");

        // reset part-way through an operation
`ifdef MDU_DIV_EN
        send(MDU_DIV, 32'd1000, 32'd3);
`else
        send(MDU_MULT, 32'd5, 32'd6);
`endif
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        send(MDU_MTHI, 32'h0000_1234, 32'd0);        collect("mthi");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
